// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Saturation limit for a given width: most negative when neg, else most positive.
  function automatic logic [63:0] sat_limit(input int width, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// STEP-bit combinational ripple adder slice; also exposes the carry into its top bit.
module addsub_slice #(
  parameter int STEP = 2
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            cin,
  output logic [STEP-1:0] sum,
  output logic            cout,
  output logic            c_msb_in
);

  logic [STEP:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < STEP; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[STEP];
  assign c_msb_in = c[STEP-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle signed add/subtract, STEP bits per cycle, start/done handshake.
// Define ADDSUB_SATURATE_EN to saturate on overflow instead of forcing zero.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             cb
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  generate
    if ((WIDTH < 2) || (WIDTH > 64) || (STEP < 1) || (WIDTH % STEP != 0)) begin : g_bad_cfg
      $fatal(1, "addsub_serial: WIDTH must be 2..64 and divisible by STEP");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d;
  logic               mode_q, carry_q;
  logic [WIDTH-1:0]   result_q, fin_d;
  logic               ovf_q, cb_q;

  logic               accept, last;
  logic [IDX_W-1:0]   lsb;
  logic [STEP-1:0]    sl_sum;
  logic               sl_cout, sl_cmsb, ovf_now;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CNT_W'(N - 1));
  assign lsb    = IDX_W'(int'(cnt_q) * STEP);

  // One slice, time-multiplexed across the operand by cnt.
  addsub_slice #(.STEP(STEP)) u_slice (
    .a        (a_q[lsb +: STEP]),
    .b        (b_q[lsb +: STEP]),
    .cin      (carry_q),
    .sum      (sl_sum),
    .cout     (sl_cout),
    .c_msb_in (sl_cmsb)
  );

  assign ovf_now = sl_cmsb ^ sl_cout;

  always_comb begin
    acc_d              = acc_q;
    acc_d[lsb +: STEP] = sl_sum;
`ifdef ADDSUB_SATURATE_EN
    // Overflow means in1 and the effective operand share a sign, so in1's sign picks the rail.
    fin_d = ovf_now ? WIDTH'(sat_limit(WIDTH, a_q[WIDTH-1])) : acc_d;
`else
    fin_d = ovf_now ? '0 : acc_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mode_q   <= MODE_ADD;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cb_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= in1;
      b_q     <= (mode == MODE_SUB) ? ~in2 : in2;
      mode_q  <= mode;
      carry_q <= mode;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_d;
      carry_q <= sl_cout;
      cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
      if (last) begin
        result_q <= fin_d;
        ovf_q    <= ovf_now;
        cb_q     <= (mode_q == MODE_SUB) ? ~sl_cout : sl_cout;
      end
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign cb     = cb_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial (WIDTH=8, STEP=2) with an expected-result queue.
module tb_addsub_serial;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
    logic       cb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic [7:0] in1, in2;
  logic       busy, done, ovf, cb;
  logic [7:0] result;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t last_e;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .STEP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .cb(cb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [8:0] s;
    int         t;
    s     = m ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
    t     = m ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    e.ovf = (t > 127) || (t < -128);
    e.cb  = m ? ~s[8] : s[8];
`ifdef ADDSUB_SATURATE_EN
    e.res = e.ovf ? ((t > 127) ? 8'h7F : 8'h80) : s[7:0];
`else
    e.res = e.ovf ? 8'h00 : s[7:0];
`endif
    return e;
  endfunction

  // Called one time unit after an edge; the following edge accepts the request.
  task automatic do_op(input logic m, input logic [7:0] a, input logic [7:0] b, input bit pulse);
    exp_t e;
    int   lat, bcnt;
    sb_q.push_back(model(m, a, b));
    start = 1'b1; mode = m; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; in1 = ~a; in2 = 8'h5A;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      check("hold_result", result, last_e.res);
      if (pulse && lat == 2) begin
        start = 1'b1; mode = 1'b0; in1 = 8'h11; in2 = 8'h22;
      end else if (pulse && lat == 3) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 5);
    check("busy_cycles", bcnt, 4);
    e = sb_q.pop_front();
    check("result", result, e.res);
    check("ovf", ovf, e.ovf);
    check("cb", cb, e.cb);
    last_e = e;
  endtask

  task automatic step_idle();
    @(posedge clk); #1;
    check("done_pulse_end", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; in1 = '0; in2 = '0;
    last_e = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_cb", cb, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b1, 8'h05, 8'h03, 1'b0); step_idle();
    do_op(1'b0, 8'hFF, 8'h01, 1'b0); step_idle();
    do_op(1'b1, 8'h80, 8'h01, 1'b0); step_idle();
    do_op(1'b0, 8'h7F, 8'h01, 1'b0); step_idle();
    do_op(1'b0, 8'h80, 8'hFF, 1'b0); step_idle();
    do_op(1'b1, 8'h7F, 8'hFF, 1'b0); step_idle();
    do_op(1'b0, 8'h25, 8'h13, 1'b0); step_idle();

    // start pulse during RUN must not spawn a second operation
    do_op(1'b0, 8'h10, 8'h20, 1'b1); step_idle();
    repeat (3) begin
      @(posedge clk); #1;
      check("no_extra_done", done, 0);
    end

    // back-to-back: second start lands in the DONE cycle
    do_op(1'b0, 8'h01, 8'h02, 1'b0);
    do_op(1'b1, 8'h03, 8'h05, 1'b0);
    step_idle();

    // abort in the second RUN cycle
    start = 1'b1; mode = 1'b0; in1 = 8'h40; in2 = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_run1", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_ovf", ovf, 0);
    check("abort_cb", cb, 0);
    last_e = '0;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end

    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1; mode = 1'b0; in1 = 8'h01; in2 = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_wins_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_wins_idle", busy, 0);

    do_op(1'b1, 8'h05, 8'h03, 1'b0); step_idle();
    do_op(1'b0, 8'h7F, 8'h01, 1'b0); step_idle();

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
